// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_pkg;

    // Controller phases: serial load, optional functional capture, serial unload.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPT,
        UNLOAD,
        DONE
    } scan_state_t;

    // Value driven on SCANIN while the captured contents are shifted out.
    localparam logic UNLOAD_FILL = 1'b0;

endpackage

// File: rtl/scan_shreg.sv
// Shift register with parallel load: serial in at the LSB, serial out at the MSB.
// o_nxt is the value that will be registered on the coming edge.
module scan_shreg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_din,
    input  logic         i_en,
    input  logic         i_si,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_nxt,
    output logic         o_so
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_shift;
    logic [W-1:0] w_nxt;

    generate
        if (W == 1) begin : g_one
            assign w_shift = i_si;
        end else begin : g_multi
            assign w_shift = {r_q[W-2:0], i_si};
        end
    endgenerate

    // Load has priority over shifting; otherwise hold.
    always_comb begin
        w_nxt = r_q;
        if (i_load)
            w_nxt = i_din;
        else if (i_en)
            w_nxt = w_shift;
    end

    // Register the selected value.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr)
            r_q <= '0;
        else
            r_q <= w_nxt;
    end

    assign o_q   = r_q;
    assign o_nxt = w_nxt;
    assign o_so  = r_q[W-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: loads a pattern serially, optionally pulses one
// functional capture cycle, and unloads the chain into RESULT.
// Optional compare against an expected value: define SCAN_CHAIN_CMP_EN.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_start,
    input  logic                 i_capture,
    input  logic                 i_abort,
    input  logic [CHAIN_LEN-1:0] i_pattern,
    input  logic                 i_scanout,
    output logic                 o_test,
    output logic                 o_scanin,
    output logic                 o_hold,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_result
`ifdef SCAN_CHAIN_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] i_expect,
    output logic                 o_fail
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_cap;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_in_busy;
    logic                 w_kill;
    logic                 r_test, r_hold, r_busy, r_done;
    logic                 w_test_nxt, w_hold_nxt, w_busy_nxt, w_done_nxt;

    logic [CHAIN_LEN-1:0] w_pat_q, w_pat_nxt;
    logic                 w_pat_so;
    logic [CHAIN_LEN-1:0] w_res_q, w_res_nxt;
    logic                 w_res_so;
    logic                 w_unused;

    assign w_last    = (r_cnt == LAST);
    assign w_in_busy = (r_state == SHIFT) || (r_state == CAPT) || (r_state == UNLOAD);
    assign w_kill    = i_abort && w_in_busy;

    // Next state, shift counter and the registered output values they imply.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (i_start && !i_abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (i_abort)
                    w_state_nxt = IDLE;
                else if (w_last)
                    w_state_nxt = r_cap ? CAPT : DONE;
                else
                    w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            CAPT: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = UNLOAD;
                    w_cnt_nxt   = '0;
                end
            end
            UNLOAD: begin
                if (i_abort)
                    w_state_nxt = IDLE;
                else if (w_last)
                    w_state_nxt = DONE;
                else
                    w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            default: w_state_nxt = IDLE;
        endcase

        w_test_nxt = 1'b0;
        w_hold_nxt = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            SHIFT, UNLOAD: begin
                w_test_nxt = 1'b1;
                w_hold_nxt = 1'b0;
                w_busy_nxt = 1'b1;
            end
            CAPT: begin
                w_hold_nxt = 1'b0;
                w_busy_nxt = 1'b1;
            end
            DONE:    w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, counter and chain-control outputs.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_test  <= 1'b0;
            r_hold  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_test  <= w_test_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Capture request is latched together with the pattern.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr)
            r_cap <= 1'b0;
        else if (w_accept)
            r_cap <= i_capture;
    end

    // Pattern source: its MSB is SCANIN. Zero fill leaves it empty after the
    // load phase, so SCANIN reads the fill value during capture and unload;
    // an abort empties it so SCANIN drops immediately.
    scan_shreg #(.W(CHAIN_LEN)) u_pat (
        .i_clk  (i_clk),
        .i_clr  (i_clr),
        .i_load (w_accept || w_kill),
        .i_din  (w_accept ? i_pattern : '0),
        .i_en   (r_state == SHIFT),
        .i_si   (UNLOAD_FILL),
        .o_q    (w_pat_q),
        .o_nxt  (w_pat_nxt),
        .o_so   (w_pat_so)
    );

    // Unload register: collects SCANOUT on every shift edge.
    scan_shreg #(.W(CHAIN_LEN)) u_res (
        .i_clk  (i_clk),
        .i_clr  (i_clr),
        .i_load (1'b0),
        .i_din  ('0),
        .i_en   ((r_state == SHIFT) || (r_state == UNLOAD)),
        .i_si   (i_scanout),
        .o_q    (w_res_q),
        .o_nxt  (w_res_nxt),
        .o_so   (w_res_so)
    );

    assign w_unused = ^{w_pat_q, w_pat_nxt, w_res_so, w_res_nxt};

`ifdef SCAN_CHAIN_CMP_EN
    logic [CHAIN_LEN-1:0] r_expect;
    logic                 r_fail;

    // Expected value travels with the pattern.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr)
            r_expect <= '0;
        else if (w_accept)
            r_expect <= i_expect;
    end

    // Compare the final unloaded value as it is registered, so FAIL is valid with DONE.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr)
            r_fail <= 1'b0;
        else if (w_accept || i_abort)
            r_fail <= 1'b0;
        else if (w_state_nxt == DONE)
            r_fail <= (w_res_nxt != r_expect);
    end

    assign o_fail = r_fail;
`endif

    assign o_test   = r_test;
    assign o_scanin = w_pat_so;
    assign o_hold   = r_hold;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = w_res_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a behavioural scan chain on the clock.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr, start, capture, abort, scanout;
    logic [N-1:0] pattern, expect_v;
    logic         test, scanin, hold, busy, done;
    logic [N-1:0] result;
`ifdef SCAN_CHAIN_CMP_EN
    logic         fail;
`endif

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .i_clk     (clk),
        .i_clr     (clr),
        .i_start   (start),
        .i_capture (capture),
        .i_abort   (abort),
        .i_pattern (pattern),
        .i_scanout (scanout),
        .o_test    (test),
        .o_scanin  (scanin),
        .o_hold    (hold),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result)
`ifdef SCAN_CHAIN_CMP_EN
        ,
        .i_expect  (expect_v),
        .o_fail    (fail)
`endif
    );

    // Behavioural chain: frozen on HOLD, shifts on TEST, else loads functional D.
    logic [N-1:0] chain, func_d, pre_val;
    logic         pre_req;
    always @(posedge clk) begin
        if (pre_req)
            chain <= pre_val;
        else if (!hold)
            chain <= test ? {chain[N-2:0], scanin} : func_d;
    end
    assign scanout = chain[N-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle view {test, hold, busy, done, scanin}.
    typedef struct packed {
        logic test;
        logic hold;
        logic busy;
        logic done;
        logic scanin;
    } cyc_t;

    task automatic run_txn(input string nm, input logic [N-1:0] pat, input logic cap,
                           input logic [N-1:0] pre, input logic [N-1:0] d,
                           input logic [N-1:0] ex, input logic [N-1:0] exp_res,
                           input logic [N-1:0] exp_chain, input int exp_lat,
                           input logic exp_fail);
        cyc_t q[$];
        cyc_t act;
        int   first_done;
        pre_req = 1'b1; pre_val = pre; func_d = d;
        step();
        pre_req = 1'b0;
        for (int i = 0; i < N; i++) q.push_back({1'b1, 1'b0, 1'b1, 1'b0, pat[N-1-i]});
        if (cap) begin
            q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
            for (int i = 0; i < N; i++) q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

        start = 1'b1; capture = cap; pattern = pat; expect_v = ex;
        step();
        start = 1'b0; pattern = N'($urandom); expect_v = N'($urandom); capture = 1'($urandom);
        first_done = -1;
        for (int k = 0; k < q.size(); k++) begin
            act = {test, hold, busy, done, scanin};
            chk($sformatf("%s cyc%0d", nm, k + 1), 32'(act), 32'(q[k]));
            if (done && first_done < 0) first_done = k + 1;
            if (k < q.size() - 1) step();
        end
        chk({nm, " latency"}, first_done, exp_lat);
        chk({nm, " result"}, result, exp_res);
        chk({nm, " chain"}, chain, exp_chain);
`ifdef SCAN_CHAIN_CMP_EN
        chk({nm, " fail"}, fail, exp_fail);
`endif
        step();
        chk({nm, " idle after"}, {busy, done, test, hold}, 4'b0001);
    endtask

    typedef struct {
        logic [N-1:0] pat;
        logic         cap;
        logic [N-1:0] pre, d, ex, res, chn;
        int           lat;
        logic         fl;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic         seen;
        logic [N-1:0] rp, rpre, rd, rex, rres, rchn;
        logic         rcap;

        tbl[0] = '{8'hA5, 1'b0, 8'h3C, 8'h00, 8'h3C, 8'h3C, 8'hA5, N + 1,     1'b0};
        tbl[1] = '{8'hFF, 1'b1, 8'h5A, 8'h0F, 8'h0F, 8'h0F, 8'h00, 2 * N + 2, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 8'h3D, 8'h00, 8'h3C, 8'h3D, 8'h00, N + 1,     1'b1};
        tbl[3] = '{8'h00, 1'b0, 8'h3D, 8'h00, 8'h3D, 8'h3D, 8'h00, N + 1,     1'b0};
        tbl[4] = '{8'h81, 1'b1, 8'hC3, 8'h7E, 8'h00, 8'h7E, 8'h00, 2 * N + 2, 1'b1};

        clr = 1'b1; start = 1'b0; capture = 1'b0; abort = 1'b0;
        pattern = '0; expect_v = '0; func_d = '0; pre_req = 1'b1; pre_val = '0;

        // Reset values appear before any clock edge.
        #1;
        chk("rst async", {test, scanin, hold, busy, done}, 5'b00100);
        chk("rst result", result, 0);
        step(); step(); step();
        clr = 1'b0; pre_req = 1'b0;
        chk("rst held", {test, scanin, hold, busy, done}, 5'b00100);

        // Reset in the middle of a shift abandons it at once.
        start = 1'b1; pattern = 8'hA5; capture = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre-clr busy", busy, 1);
        #2 clr = 1'b1;
        #1;
        chk("clr mid-shift", {test, scanin, hold, busy, done}, 5'b00100);
        chk("clr mid result", result, 0);
        step(); step(); step();
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            seen |= done | busy;
            step();
        end
        chk("no done after clr", seen, 0);

        // Table-driven transactions.
        for (int i = 0; i < 5; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].cap, tbl[i].pre, tbl[i].d,
                    tbl[i].ex, tbl[i].res, tbl[i].chn, tbl[i].lat, tbl[i].fl);

        // Abort in the 4th shift cycle, with START in the same cycle.
        pre_req = 1'b1; pre_val = 8'h3C;
        step();
        pre_req = 1'b0;
        start = 1'b1; pattern = 8'hA5; capture = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort pre busy", {test, busy}, 2'b11);
        abort = 1'b1; start = 1'b1; pattern = 8'h11;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort outputs", {test, scanin, hold, busy, done}, 5'b00100);
        seen = 1'b0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            seen |= done;
            step();
        end
        chk("abort no done", seen, 0);
        chk("abort stays idle", busy, 0);

        // START while busy is ignored; START in the DONE cycle chains a new load.
        pre_req = 1'b1; pre_val = 8'h00;
        step();
        pre_req = 1'b0;
        start = 1'b1; pattern = 8'h5A; capture = 1'b0;
        step();
        start = 1'b0;
        step();
        start = 1'b1; pattern = 8'h11;
        step();
        start = 1'b0;
        for (int i = 0; i < N - 2; i++) step();
        chk("seq1 done", done, 1);
        chk("seq1 chain", chain, 8'h5A);
        start = 1'b1; pattern = 8'h22;
        step();
        start = 1'b0;
        chk("seq2 begins", {test, busy, done, scanin}, 4'b1100);
        for (int i = 0; i < N; i++) step();
        chk("seq2 done", done, 1);
        chk("seq2 result", result, 8'h5A);
        chk("seq2 chain", chain, 8'h22);
        step();

        // Random transactions against the spec-level model.
        for (int r = 0; r < 24; r++) begin
            rp   = N'($urandom);
            rpre = N'($urandom);
            rd   = N'($urandom);
            rcap = 1'($urandom_range(0, 1));
            rres = rcap ? rd : rpre;
            rchn = rcap ? '0 : rp;
            rex  = ($urandom_range(0, 1) == 1) ? rres : N'($urandom);
            run_txn($sformatf("rnd%0d", r), rp, rcap, rpre, rd, rex, rres, rchn,
                    rcap ? 2 * N + 2 : N + 1, rres != rex);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Drives the scan side of a chain of scan/hold datapath flip-flops: TEST, SCANIN and HOLD outputs, SCANOUT input from the last stage.
- Serially loads a host-supplied pattern, optionally pulses one functional capture clock, and unloads the chain contents into a parallel result register.
- Sits between the test/debug host logic and the datapath register groups.

Parameters:
- CHAIN_LEN, 8, number of flip-flops in the chain (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), shift counter width (localparam, not overridable).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- START  in  1  request pulse; accepted only when BUSY=0.
- CAPTURE  in  1  sampled with START; 1 = shift, capture, unload.
- ABORT  in  1  cancel the current operation.
- PATTERN  in  CHAIN_LEN  pattern to load; sampled with START.
- SCANOUT  in  1  serial output of the last chain stage (Q[CHAIN_LEN-1]).
- TEST  out  1  scan-enable to the chain.
- SCANIN  out  1  serial data into chain stage 0.
- HOLD  out  1  chain hold; 1 freezes the chain.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  CHAIN_LEN  unloaded chain contents.

Behaviour:
- Reset values while CLR=1: state IDLE, TEST=0, SCANIN=0, HOLD=1, BUSY=0, DONE=0, RESULT=0, counter=0. CLR mid-operation abandons it immediately; no DONE.
- All outputs are registered.
- States:
  - IDLE → SHIFT on START.
  - SHIFT → CAPT if CAPTURE was latched, otherwise DONE.
  - CAPT → UNLOAD.
  - UNLOAD → DONE.
  - DONE → IDLE, or → SHIFT if START is sampled in the DONE cycle.
- START edge t latches PATTERN and CAPTURE. START is ignored when BUSY=1.
- SHIFT: TEST=1, HOLD=0 for exactly CHAIN_LEN cycles.
  - SCANIN presents PATTERN MSB first.
  - On each shift edge: RESULT <= {RESULT[CHAIN_LEN-2:0], SCANOUT}.
  - After CHAIN_LEN edges, chain = PATTERN and RESULT = prior chain contents.
- CAPT: TEST=0, HOLD=0 for one cycle; chain loads functional D.
- UNLOAD: same as SHIFT with SCANIN=0 for CHAIN_LEN cycles. RESULT = captured value; chain ends all-zero.
- DONE: state lasts one cycle with DONE=1, TEST=0, HOLD=1, BUSY=0.
- Latency from the START edge to DONE high: CHAIN_LEN+1 cycles without capture, 2*CHAIN_LEN+2 with capture.
- BUSY=1 in SHIFT, CAPT and UNLOAD only.
- ABORT in any busy state: next cycle IDLE, TEST=0, SCANIN=0, HOLD=1, no DONE. RESULT keeps its partially shifted value and is undefined for use. ABORT outranks START in the same cycle.
- Counter counts 0..CHAIN_LEN-1 and is reloaded to 0 on entry to SHIFT and to UNLOAD; no wrap beyond terminal count. CHAIN_LEN=1 is legal: a single shift cycle per phase.

Optional Feature:
- Macro SCAN_CHAIN_CMP_EN.
- Defined: adds input EXPECT [CHAIN_LEN] (sampled with START) and output FAIL [1]. FAIL = (RESULT != EXPECT), registered, valid in the DONE cycle, cleared on START, ABORT and CLR.
- Undefined: neither port exists and there is no compare logic.

Decomposition:
- Package scan_pkg: state enum typedef (IDLE, SHIFT, CAPT, UNLOAD, DONE) and a localparam for the SCANIN fill value during UNLOAD (0).
- One natural sub-module, scan_shreg: CHAIN_LEN-wide register with parallel load, enable, serial in at LSB and serial out at MSB. Instanced twice, once for the pattern and once for RESULT.

Test Plan (CHAIN_LEN=8; behavioural chain model on CLK):
1. Assert CLR for 3 cycles, including mid-SHIFT → TEST=0, SCANIN=0, HOLD=1, BUSY=0, DONE=0, RESULT=8'h00 immediately, without waiting for a clock edge.
2. Chain preloaded 8'h3C; START with PATTERN=8'hA5, CAPTURE=0 → TEST=1 for 8 cycles, SCANIN=1,0,1,0,0,1,0,1; DONE at cycle 9; RESULT=8'h3C; chain=8'hA5.
3. Chain D=8'h0F; START with PATTERN=8'hFF, CAPTURE=1 → 8 shift cycles, then 1 cycle TEST=0/HOLD=0, then 8 unload cycles with SCANIN=0; DONE at cycle 18; RESULT=8'h0F; chain=8'h00.
4. ABORT during the 4th shift cycle (START asserted in the same cycle) → next cycle TEST=0, HOLD=1, BUSY=0; DONE never asserted.
5. START with PATTERN=8'h11 while BUSY → ignored (chain ends at the first pattern). START with PATTERN=8'h22 in the DONE cycle → new SHIFT begins next cycle; the second RESULT equals the first pattern.
6. With SCAN_CHAIN_CMP_EN: EXPECT=8'h3C, chain 8'h3D → FAIL=1 with DONE. EXPECT=8'h3D → FAIL=0.
